// File: rtl/text_source_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_source_ctrl_pkg : state encoding and terminator shared by text source/sink
// rev 1.0
// ---------------------------------------------------------------------------
package text_source_ctrl_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  localparam logic [7:0] TERM_BYTE_DEF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_ISSUE   = S_ISSUE,
    ST_WAIT    = S_WAIT,
    ST_PRESENT = S_PRESENT,
    ST_FINISH  = S_FINISH
  } state_t;

endpackage
`default_nettype wire

// File: rtl/text_out_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_out_reg : output byte holding register with valid/ready hold logic
// rev 1.0
// ---------------------------------------------------------------------------
module text_out_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              fire
);

  assign fire = valid & ready;

  // data only changes on load, so it stays stable for the whole stall
  always_ff @(posedge clk) begin
    if (!reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/text_source_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// text_source_ctrl : walks the text ROM and streams bytes over valid/ready
// rev 1.0
// ---------------------------------------------------------------------------
module text_source_ctrl
  import text_source_ctrl_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                RD_LAT    = 1,
  parameter logic [DATA_W-1:0] TERM_BYTE = DATA_W'(TERM_BYTE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rden,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int                LAT_W     = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LAT - 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             rom_valid;
  logic             load_byte;
  logic             tx_fire;

  assign rom_valid = (state == ST_WAIT) && (lat_cnt == '0);
  assign load_byte = rom_valid && (rom_q != TERM_BYTE);

  // done is qualified by loop_en during the single FINISH cycle
  assign done = (state == ST_FINISH) && !loop_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      rom_rden <= 1'b0;
      busy     <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      rom_rden <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            rom_rden <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          lat_cnt <= LAT_LOAD;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state <= (rom_q == TERM_BYTE) ? ST_FINISH : ST_PRESENT;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_PRESENT: begin
          if (tx_fire) begin
            if (rom_addr == LAST_ADDR) begin
              state <= ST_FINISH;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              rom_rden <= 1'b1;
              state    <= ST_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          if (loop_en) begin
            rom_addr <= '0;
            rom_rden <= 1'b1;
            state    <= ST_ISSUE;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  text_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (load_byte),
    .load_data (rom_q),
    .ready     (tx_ready),
    .data      (tx_data),
    .valid     (tx_valid),
    .fire      (tx_fire)
  );

endmodule
`default_nettype wire

// File: tb/tb_text_source_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_text_source_ctrl : scoreboard bench for text_source_ctrl
// rev 1.0
// ---------------------------------------------------------------------------
module tb_text_source_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       loop_en;
  logic [7:0] rom_addr;
  logic       rom_rden;
  logic [7:0] rom_q;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;

  logic       s_start;
  logic [1:0] s_addr;
  logic       s_rden;
  logic [7:0] s_p1;
  logic [7:0] s_q;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       s_busy;
  logic       s_done;

  logic [7:0] rom_mem [256];
  logic [7:0] mem2    [4];

  int cyc = 0;

  text_source_ctrl #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .start(start), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_rden(rom_rden), .rom_q(rom_q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  text_source_ctrl #(.ADDR_W(2), .DATA_W(8), .RD_LAT(2)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .loop_en(1'b0),
    .rom_addr(s_addr), .rom_rden(s_rden), .rom_q(s_q),
    .tx_data(s_data), .tx_valid(s_valid), .tx_ready(s_ready),
    .busy(s_busy), .done(s_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rom_rden) rom_q <= rom_mem[rom_addr];
  end

  always @(posedge clk) begin
    if (s_rden) s_p1 <= mem2[s_addr];
    s_q <= s_p1;
  end

  typedef struct {
    logic [31:0] msg;
    int          mode;
    int          nbytes;
    int          nreads;
    int          first_lat;
  } vec_t;

  vec_t vecs [4];

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q   [$];
  logic [7:0] s_exp_q [$];

  int ready_mode = 0;
  int stall_left = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = '0;
  logic       seen_valid = 1'b0;
  int valid_cyc = 0;
  int done_cyc  = 0;
  int hs_cnt    = 0;
  int rden_cnt  = 0;
  int done_cnt  = 0;

  int s_hs = 0, s_rd = 0, s_dn = 0, s_next = 0, s_first = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // one cycle: drive ready, then monitor and score both DUTs
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    case (ready_mode)
      0: tx_ready = 1'b1;
      1: begin
        if (tx_valid && stall_left > 0) begin
          tx_ready = 1'b0;
          stall_left--;
        end else begin
          tx_ready = 1'b1;
        end
      end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (hold_pend) begin
      check("hold_valid", 32'(tx_valid), 32'd1);
      check("hold_data", 32'(tx_data), 32'(hold_data));
    end
    hold_pend = tx_valid && !tx_ready;
    hold_data = tx_data;
    if (tx_valid && !seen_valid) begin
      seen_valid = 1'b1;
      valid_cyc  = cyc;
    end
    if (tx_valid && tx_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        timeout("unexpected_byte");
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", 32'(tx_data), 32'(e));
      end
    end
    if (rom_rden) rden_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_valid && s_first < 0) s_first = cyc;
    if (s_valid && s_ready) begin
      s_hs++;
      if (s_exp_q.size() == 0) begin
        timeout("small_unexpected_byte");
      end else begin
        e = s_exp_q.pop_front();
        check("small_byte", 32'(s_data), 32'(e));
      end
    end
    if (s_rden) begin
      check("small_addr", 32'(s_addr), 32'(s_next));
      s_next++;
      s_rd++;
    end
    if (s_done) s_dn++;
  endtask

  task automatic wait_done(input int limit, input string name);
    int b;
    int n;
    b = done_cnt;
    n = 0;
    while (done_cnt == b && n < limit) begin
      tick();
      n++;
    end
    if (done_cnt == b) timeout(name);
  endtask

  task automatic load_msg(input logic [31:0] msg);
    logic [7:0] b;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) rom_mem[i] = msg[8*i +: 8];
    for (int i = 0; i < 4; i++) begin
      b = msg[8*i +: 8];
      if (b == 8'h00) break;
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start(output int st);
    start      = 1'b1;
    st         = cyc;
    seen_valid = 1'b0;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int st, b_hs, b_rd, b_dn, n;
    reset   = 1'b0;
    start   = 1'b0;
    loop_en = 1'b0;
    tx_ready = 1'b1;
    s_start = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem2[i] = 8'(i + 1);

    vecs[0] = '{msg: 32'h0000_4948, mode: 0, nbytes: 2, nreads: 3, first_lat: 3};
    vecs[1] = '{msg: 32'h0000_4948, mode: 1, nbytes: 2, nreads: 3, first_lat: 3};
    vecs[2] = '{msg: 32'h0000_0000, mode: 0, nbytes: 0, nreads: 1, first_lat: 3};
    vecs[3] = '{msg: 32'h0043_4241, mode: 2, nbytes: 3, nreads: 4, first_lat: 3};

    repeat (3) tick();
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_rden", 32'(rom_rden), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 4; v++) begin
      load_msg(vecs[v].msg);
      ready_mode = vecs[v].mode;
      stall_left = 5;
      b_hs = hs_cnt; b_rd = rden_cnt; b_dn = done_cnt;
      pulse_start(st);
      check("busy_after_start", 32'(busy), 32'd1);
      wait_done(300, "vec_done");
      if (vecs[v].nbytes > 0) check("first_valid_lat", 32'(valid_cyc - st), 32'(vecs[v].first_lat));
      else check("empty_done_lat", 32'(done_cyc - st), 32'(vecs[v].first_lat));
      if (vecs[v].nbytes == 0) check("empty_no_valid", 32'(seen_valid), 32'd0);
      tick();
      check("vec_busy_low", 32'(busy), 32'd0);
      check("vec_done_pulse", 32'(done), 32'd0);
      check("vec_handshakes", 32'(hs_cnt - b_hs), 32'(vecs[v].nbytes));
      check("vec_reads", 32'(rden_cnt - b_rd), 32'(vecs[v].nreads));
      check("vec_dones", 32'(done_cnt - b_dn), 32'd1);
      check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) tick();
    end

    // small ROM with no terminator: must stop at the last address
    ready_mode = 0;
    s_next = 0;
    for (int i = 0; i < 4; i++) s_exp_q.push_back(mem2[i]);
    s_start = 1'b1;
    st = cyc;
    tick();
    s_start = 1'b0;
    n = 0;
    while (s_dn == 0 && n < 100) begin tick(); n++; end
    if (s_dn == 0) timeout("small_done");
    check("small_first_lat", 32'(s_first - st), 32'd4);
    check("small_last_addr", 32'(s_addr), 32'd3);
    tick();
    check("small_busy_low", 32'(s_busy), 32'd0);
    check("small_handshakes", 32'(s_hs), 32'd4);
    check("small_reads", 32'(s_rd), 32'd4);
    check("small_dones", 32'(s_dn), 32'd1);

    // looping message, then release loop_en
    load_msg(32'h0000_4241);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back((i % 2 == 0) ? 8'h41 : 8'h42);
    loop_en = 1'b1;
    b_hs = hs_cnt; b_rd = rden_cnt; b_dn = done_cnt;
    pulse_start(st);
    n = 0;
    while (hs_cnt - b_hs < 20 && n < 200) begin tick(); n++; end
    if (hs_cnt - b_hs < 20) timeout("loop_bytes");
    check("loop_no_done", 32'(done_cnt - b_dn), 32'd0);
    check("loop_busy", 32'(busy), 32'd1);
    loop_en = 1'b0;
    wait_done(50, "loop_end_done");
    tick();
    check("loop_handshakes", 32'(hs_cnt - b_hs), 32'd20);
    check("loop_reads", 32'(rden_cnt - b_rd), 32'd30);
    check("loop_busy_low", 32'(busy), 32'd0);

    // reset while waiting on the second byte
    load_msg(32'h0000_4948);
    b_dn = done_cnt;
    pulse_start(st);
    n = 0;
    while (!(tx_valid && tx_ready) && n < 50) begin tick(); n++; end
    tick();
    tick();
    check("wait_addr", 32'(rom_addr), 32'd1);
    reset = 1'b0;
    hold_pend = 1'b0;
    tick();
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(rom_addr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("abort_no_done", 32'(done_cnt - b_dn), 32'd0);

    // replay, with extra starts while busy and one coinciding with done
    load_msg(32'h0000_4948);
    b_hs = hs_cnt; b_rd = rden_cnt; b_dn = done_cnt;
    pulse_start(st);
    tick();
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    wait_done(100, "replay_done");
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("replay_handshakes", 32'(hs_cnt - b_hs), 32'd2);
    check("replay_reads", 32'(rden_cnt - b_rd), 32'd3);
    check("replay_dones", 32'(done_cnt - b_dn), 32'd1);
    check("start_at_done_busy", 32'(busy), 32'd0);
    check("start_at_done_valid", 32'(tx_valid), 32'd0);
    check("replay_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
